// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback. A bounded wait counter traps stalled memory accesses.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       MUXsel,
    output logic [3:0] alu_ctrl,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_dst,
    output logic       wb_sel,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      op_q, op_d;
    logic [5:0]      fn_q, fn_d;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Immediate-form instructions always add (address or addi); R-type follows funct.
    function automatic logic [3:0] alu_decode(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] code;
        if (op == OP_RTYPE) begin
            case (fn)
                FN_ADD:  code = ALU_ADD;
                FN_SUB:  code = ALU_SUB;
                FN_AND:  code = ALU_AND;
                FN_OR:   code = ALU_OR;
                FN_SLT:  code = ALU_SLT;
                default: code = ALU_AND;
            endcase
        end else begin
            code = ALU_ADD;
        end
        return code;
    endfunction

    // State, wait counter and captured instruction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 6'h00;
            fn_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    // Next-state logic; the counter defaults to zero so every entry into FETCH/MEM starts clean.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        op_d    = op_q;
        fn_d    = fn_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                fn_d = funct;
                if (is_legal(opcode, funct)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A ready strobe in the final wait cycle still completes the access.
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else if (run) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WB: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode; only the FETCH write enables look at mem_ready.
    always_comb begin
        MUXsel   = 1'b0;
        alu_ctrl = 4'b0000;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        reg_we   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_dst  = 1'b0;
        wb_sel   = 1'b0;
        busy     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_EXEC: begin
                busy     = 1'b1;
                MUXsel   = (op_q != OP_RTYPE);
                alu_ctrl = alu_decode(op_q, fn_q);
            end
            S_MEM: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_we   = (op_q == OP_SW);
                MUXsel   = (op_q != OP_RTYPE);
                alu_ctrl = alu_decode(op_q, fn_q);
            end
            S_WB: begin
                busy     = 1'b1;
                reg_we   = 1'b1;
                reg_dst  = (op_q == OP_RTYPE);
                wb_sel   = (op_q == OP_LW);
                MUXsel   = (op_q != OP_RTYPE);
                alu_ctrl = alu_decode(op_q, fn_q);
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                err = 1'b0;
            end
        endcase
    end

endmodule
